// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stage sequencer: FSM state encoding,
// stage indices and the En/Flush patterns driven onto the register banks.
package pipe_ctrl_pkg;

  localparam int unsigned N_STAGES = 5;
  localparam int unsigned LU_W     = 4;

  // Stage indices into En/Flush
  localparam int unsigned STG_PC    = 0;
  localparam int unsigned STG_IFID  = 1;
  localparam int unsigned STG_IDEX  = 2;
  localparam int unsigned STG_EXMEM = 3;
  localparam int unsigned STG_WB    = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LUSTALL = 2'd1,
    HALT    = 2'd2
  } state_e;

  localparam logic [N_STAGES-1:0] EN_NONE   = '0;
  localparam logic [N_STAGES-1:0] FL_NONE   = '0;
  localparam logic [N_STAGES-1:0] EN_ALL    = N_STAGES'((1 << STG_PC) | (1 << STG_IFID) |
                                                        (1 << STG_IDEX) | (1 << STG_EXMEM) |
                                                        (1 << STG_WB));
  // PC and IF/ID hold, EX/MEM and MEM/WB drain
  localparam logic [N_STAGES-1:0] EN_STALL  = N_STAGES'((1 << STG_EXMEM) | (1 << STG_WB));
  // Bubble into ID/EX
  localparam logic [N_STAGES-1:0] FL_BUBBLE = N_STAGES'(1 << STG_IDEX);
  // Squash the two wrong-path instructions behind a mispredicted branch
  localparam logic [N_STAGES-1:0] FL_REDIR  = N_STAGES'((1 << STG_IFID) | (1 << STG_IDEX));

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: Clock, Reset_n (async, active-low), inc, clr, count[CNT_W-1:0].
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Central sequencer for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register banks.
// Resolves halt / memory freeze / mispredict / load-use requests into per-stage
// ClockEnable (En) and clear (Flush) strobes, generates the shared Tick and
// keeps saturating stall and flush statistics.
// Ports: Clock, Reset_n (async, active-low); LoadUse, Mispredict, MemBusy,
// HaltReq, Resume, CntClr requests; Tick, En[4:0], Flush[4:0], Halted,
// StallCnt, FlushCnt outputs. En/Flush are combinational (act on the same edge).
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned LU_CYCLES = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                LoadUse,
  input  logic                Mispredict,
  input  logic                MemBusy,
  input  logic                HaltReq,
  input  logic                Resume,
  input  logic                CntClr,
  output logic                Tick,
  output logic [N_STAGES-1:0] En,
  output logic [N_STAGES-1:0] Flush,
  output logic                Halted,
  output logic [CNT_W-1:0]    StallCnt,
  output logic [CNT_W-1:0]    FlushCnt
);

  localparam int unsigned       DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [LU_W-1:0]   LU_INIT  = LU_W'(LU_CYCLES - 1);

  logic [DIV_W-1:0]    div_q;
  logic                tick_c;
  state_e              state_q, state_nx;
  logic [LU_W-1:0]     lu_q, lu_nx;
  logic [N_STAGES-1:0] en_c, flush_c;
  logic                stall_inc_c, flush_inc_c;

  // Tick divider: Tick on the last count of each period
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Reset_n gates Tick so every strobe is quiet while reset is held
  assign tick_c = Reset_n && (div_q == DIV_LAST);

  // FSM state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      lu_q    <= '0;
    end else begin
      state_q <= state_nx;
      lu_q    <= lu_nx;
    end
  end

  // Next state and Mealy strobes; priority HaltReq > MemBusy > Mispredict > LoadUse
  always_comb begin
    state_nx    = state_q;
    lu_nx       = lu_q;
    en_c        = EN_NONE;
    flush_c     = FL_NONE;
    stall_inc_c = 1'b0;
    flush_inc_c = 1'b0;
    if (tick_c) begin
      case (state_q)
        HALT: begin
          if (Resume) state_nx = RUN;
        end
        RUN, LUSTALL: begin
          if (HaltReq) begin
            state_nx = HALT;
            lu_nx    = '0;
          end else if (MemBusy) begin
            // Freeze keeps any pending load-use stall intact
            stall_inc_c = 1'b1;
          end else if (Mispredict) begin
            en_c        = EN_ALL;
            flush_c     = FL_REDIR;
            state_nx    = RUN;
            lu_nx       = '0;
            flush_inc_c = 1'b1;
          end else if (state_q == LUSTALL) begin
            en_c        = EN_STALL;
            flush_c     = FL_BUBBLE;
            stall_inc_c = 1'b1;
            lu_nx       = lu_q - LU_W'(1);
            if (lu_q == LU_W'(1)) state_nx = RUN;
          end else if (LoadUse) begin
            en_c        = EN_STALL;
            flush_c     = FL_BUBBLE;
            stall_inc_c = 1'b1;
            if (LU_CYCLES > 1) begin
              state_nx = LUSTALL;
              lu_nx    = LU_INIT;
            end
          end else begin
            en_c = EN_ALL;
          end
        end
        default: begin
          state_nx = RUN;
          lu_nx    = '0;
        end
      endcase
    end
  end

  assign Tick   = tick_c;
  assign En     = en_c;
  assign Flush  = flush_c;
  assign Halted = (state_q == HALT);

  // Statistics counters; CntClr acts regardless of Tick
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .inc     (stall_inc_c),
    .clr     (CntClr),
    .count   (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .inc     (flush_inc_c),
    .clr     (CntClr),
    .count   (FlushCnt)
  );

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: three configurations driven by shared inputs,
// directed scenarios followed by random traffic, each checked against a
// behavioural model of the stall/flush/halt rules.
module tb_pipe_stage_ctrl;

  logic Clock = 1'b0;
  logic Reset_n, LoadUse, Mispredict, MemBusy, HaltReq, Resume, CntClr;

  logic        tick_o [3];
  logic [4:0]  en_o   [3];
  logic [4:0]  fl_o   [3];
  logic        halt_o [3];
  logic [15:0] sc_o   [3];
  logic [15:0] fc_o   [3];
  logic [1:0]  sc2, fc2;

  int n_assert = 0;
  int n_fail   = 0;

  // Configuration of each instance
  int P_DIV [3] = '{1, 1, 4};
  int P_LU  [3] = '{2, 3, 1};
  int P_MAX [3] = '{65535, 65535, 3};

  // Model: cycle position in tick period, forced stall cycles left, halt flag, counters
  int m_phase [3];
  int m_left  [3];
  int m_halt  [3];
  int m_sc    [3];
  int m_fc    [3];

  always #5 Clock = ~Clock;

  pipe_stage_ctrl #(.TICK_DIV(1), .LU_CYCLES(2), .CNT_W(16)) u0 (
    .Clock(Clock), .Reset_n(Reset_n), .LoadUse(LoadUse), .Mispredict(Mispredict),
    .MemBusy(MemBusy), .HaltReq(HaltReq), .Resume(Resume), .CntClr(CntClr),
    .Tick(tick_o[0]), .En(en_o[0]), .Flush(fl_o[0]), .Halted(halt_o[0]),
    .StallCnt(sc_o[0]), .FlushCnt(fc_o[0]));

  pipe_stage_ctrl #(.TICK_DIV(1), .LU_CYCLES(3), .CNT_W(16)) u1 (
    .Clock(Clock), .Reset_n(Reset_n), .LoadUse(LoadUse), .Mispredict(Mispredict),
    .MemBusy(MemBusy), .HaltReq(HaltReq), .Resume(Resume), .CntClr(CntClr),
    .Tick(tick_o[1]), .En(en_o[1]), .Flush(fl_o[1]), .Halted(halt_o[1]),
    .StallCnt(sc_o[1]), .FlushCnt(fc_o[1]));

  pipe_stage_ctrl #(.TICK_DIV(4), .LU_CYCLES(1), .CNT_W(2)) u2 (
    .Clock(Clock), .Reset_n(Reset_n), .LoadUse(LoadUse), .Mispredict(Mispredict),
    .MemBusy(MemBusy), .HaltReq(HaltReq), .Resume(Resume), .CntClr(CntClr),
    .Tick(tick_o[2]), .En(en_o[2]), .Flush(fl_o[2]), .Halted(halt_o[2]),
    .StallCnt(sc2), .FlushCnt(fc2));

  assign sc_o[2] = {14'd0, sc2};
  assign fc_o[2] = {14'd0, fc2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural rules for one Tick-qualified cycle of instance k
  task automatic model_eval(input int k, output logic tk, output logic [4:0] e,
                            output logic [4:0] f, output int si, output int fi,
                            output int left_n, output int halt_n);
    tk = (m_phase[k] == P_DIV[k] - 1);
    e = 5'h00; f = 5'h00; si = 0; fi = 0;
    left_n = m_left[k]; halt_n = m_halt[k];
    if (tk) begin
      if (m_halt[k] != 0) begin
        if (Resume) halt_n = 0;
      end else if (HaltReq) begin
        halt_n = 1; left_n = 0;
      end else if (MemBusy) begin
        si = 1;
      end else if (Mispredict) begin
        e = 5'h1F; f = 5'h06; fi = 1; left_n = 0;
      end else if (m_left[k] > 0 || LoadUse) begin
        e = 5'h18; f = 5'h04; si = 1;
        left_n = (m_left[k] > 0) ? m_left[k] - 1 : P_LU[k] - 1;
      end else begin
        e = 5'h1F;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_phase[k] = 0; m_left[k] = 0; m_halt[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic check_models();
    logic tk; logic [4:0] e, f; int si, fi, ln, hn;
    for (int k = 0; k < 3; k++) begin
      model_eval(k, tk, e, f, si, fi, ln, hn);
      chk($sformatf("u%0d.Tick", k), 32'(tick_o[k]), 32'(tk));
      chk($sformatf("u%0d.En", k), 32'(en_o[k]), 32'(e));
      chk($sformatf("u%0d.Flush", k), 32'(fl_o[k]), 32'(f));
      chk($sformatf("u%0d.Halted", k), 32'(halt_o[k]), 32'(m_halt[k]));
      chk($sformatf("u%0d.StallCnt", k), 32'(sc_o[k]), 32'(m_sc[k]));
      chk($sformatf("u%0d.FlushCnt", k), 32'(fc_o[k]), 32'(m_fc[k]));
    end
  endtask

  task automatic model_update();
    logic tk; logic [4:0] e, f; int si, fi, ln, hn;
    for (int k = 0; k < 3; k++) begin
      model_eval(k, tk, e, f, si, fi, ln, hn);
      m_left[k] = ln;
      m_halt[k] = hn;
      if (CntClr) begin
        m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        if (si != 0 && m_sc[k] < P_MAX[k]) m_sc[k]++;
        if (fi != 0 && m_fc[k] < P_MAX[k]) m_fc[k]++;
      end
      m_phase[k] = (m_phase[k] + 1) % P_DIV[k];
    end
  endtask

  // Drive inputs in the low phase, let them settle, compare against the model
  task automatic apply(input logic lu, input logic mp, input logic mb,
                       input logic hr, input logic rs, input logic cc);
    LoadUse = lu; Mispredict = mp; MemBusy = mb; HaltReq = hr; Resume = rs; CntClr = cc;
    #1;
    check_models();
  endtask

  task automatic adv();
    model_update();
    @(negedge Clock);
  endtask

  // Drain stalls, leave halt, then clear counters
  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); adv();
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); adv();
  endtask

  initial begin
    Reset_n = 1'b0;
    LoadUse = 1'b0; Mispredict = 1'b0; MemBusy = 1'b0;
    HaltReq = 1'b0; Resume = 1'b0; CntClr = 1'b0;
    model_reset();
    @(negedge Clock);
    // Requests are irrelevant while reset is held
    LoadUse = 1'b1; Mispredict = 1'b1;
    @(negedge Clock);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst u%0d.Tick", k), 32'(tick_o[k]), 32'd0);
      chk($sformatf("rst u%0d.En", k), 32'(en_o[k]), 32'd0);
      chk($sformatf("rst u%0d.Flush", k), 32'(fl_o[k]), 32'd0);
      chk($sformatf("rst u%0d.Halted", k), 32'(halt_o[k]), 32'd0);
      chk($sformatf("rst u%0d.StallCnt", k), 32'(sc_o[k]), 32'd0);
    end
    Reset_n = 1'b1;
    model_reset();

    // Idle after reset
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle Tick", 32'(tick_o[0]), 32'd1);
    chk("idle En", 32'(en_o[0]), 32'h1F);
    chk("idle Flush", 32'(fl_o[0]), 32'h00);
    chk("idle StallCnt", 32'(sc_o[0]), 32'd0);
    adv();

    // Load-use with two stall cycles (u0)
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu c1 En", 32'(en_o[0]), 32'h18);
    chk("lu c1 Flush", 32'(fl_o[0]), 32'h04);
    adv();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu c2 En", 32'(en_o[0]), 32'h18);
    chk("lu c2 Flush", 32'(fl_o[0]), 32'h04);
    adv();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu c3 En", 32'(en_o[0]), 32'h1F);
    chk("lu StallCnt", 32'(sc_o[0]), 32'd2);
    adv();

    // Mispredict aborting a three-cycle load-use stall (u1)
    settle();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lump En", 32'(en_o[1]), 32'h1F);
    chk("lump Flush", 32'(fl_o[1]), 32'h06);
    adv();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lump next En", 32'(en_o[1]), 32'h1F);
    chk("lump FlushCnt", 32'(fc_o[1]), 32'd1);
    chk("lump StallCnt", 32'(sc_o[1]), 32'd1);
    adv();

    // MemBusy dominates Mispredict (u0)
    settle();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mb En", 32'(en_o[0]), 32'h00);
      chk("mb Flush", 32'(fl_o[0]), 32'h00);
      adv();
    end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mb release Flush", 32'(fl_o[0]), 32'h06);
    chk("mb StallCnt", 32'(sc_o[0]), 32'd3);
    adv();

    // Halt, ignored mispredict, resume (u0)
    settle();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("halt req En", 32'(en_o[0]), 32'h00);
    adv();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt Halted", 32'(halt_o[0]), 32'd1);
    chk("halt mp Flush", 32'(fl_o[0]), 32'h00);
    adv();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume cycle En", 32'(en_o[0]), 32'h00);
    adv();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resumed Halted", 32'(halt_o[0]), 32'd0);
    chk("resumed En", 32'(en_o[0]), 32'h1F);
    chk("resumed FlushCnt", 32'(fc_o[0]), 32'd0);
    adv();

    // Divided Tick and saturation (u2)
    settle();
    for (int i = 0; i < 8 && m_phase[2] != 0; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); adv();
    for (int i = 1; i < 21; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("div Tick", 32'(tick_o[2]), (i % 4 == 3) ? 32'd1 : 32'd0);
      chk("div StallCnt", 32'(sc_o[2]), (i / 4 > 3) ? 32'd3 : 32'(i / 4));
      adv();
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr nontick Tick", 32'(tick_o[2]), 32'd0);
    adv();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr StallCnt", 32'(sc_o[2]), 32'd0);
    adv();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      apply(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0));
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
